prbs_sweep_ctrl: RTL and testbench

PRBS_SWEEP_CTRL -- requirements
Module: prbs_sweep_ctrl

---
 rtl/prbs_sweep_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_prbs_sweep_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_sweep_ctrl.sv
// PRBS sweep controller: seeds the generator for each selected type,
// measures the repeat period of its output and reports pass/fail per type.
module prbs_sweep_ctrl #(
    parameter int unsigned INIT_CYCLES = 5
) (
    input  logic        clock_i,
    input  logic        init_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [8:0]  type_mask_i,
    input  logic [31:0] gen_out_i,
    output logic        gen_init_o,
    output logic [3:0]  gen_type_o,
    output logic        busy_o,
    output logic        result_valid_o,
    output logic [3:0]  result_type_o,
    output logic        result_pass_o,
    output logic [31:0] result_period_o,
    output logic [8:0]  pass_mask_o,
    output logic        done_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SELECT = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_REPORT = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;

    localparam int unsigned LW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [LW-1:0] LOAD_LAST = LW'(INIT_CYCLES - 1);

    logic [2:0]    state_q, state_d;
    logic [8:0]    mask_q, mask_d;
    logic [3:0]    type_q, type_d;
    logic [31:0]   count_q, count_d;
    logic [31:0]   begin_q, begin_d;
    logic [LW-1:0] lcnt_q, lcnt_d;
    logic          gen_init_q, gen_init_d;
    logic          busy_q, busy_d;
    logic [3:0]    rtype_q, rtype_d;
    logic          rpass_q, rpass_d;
    logic [31:0]   rperiod_q, rperiod_d;
    logic [8:0]    pmask_q, pmask_d;

    logic [3:0]    sel_k;
    logic [31:0]   exp_per;
    logic          gate;

    // Reference period of each PRBS type (2^n - 1).
    function automatic logic [31:0] exp_period(input logic [3:0] k);
        case (k)
            4'd0:    exp_period = 32'd127;
            4'd1:    exp_period = 32'd511;
            4'd2:    exp_period = 32'd1023;
            4'd3:    exp_period = 32'd2047;
            4'd4:    exp_period = 32'd32767;
            4'd5:    exp_period = 32'd1048575;
            4'd6:    exp_period = 32'd8388607;
            4'd7:    exp_period = 32'd536870911;
            4'd8:    exp_period = 32'd2147483647;
            default: exp_period = 32'd127;
        endcase
    endfunction

    // Lowest remaining set bit of the latched mask.
    always_comb begin
        sel_k = 4'd0;
        for (int i = 8; i >= 0; i--) begin
            if (mask_q[i]) sel_k = 4'(i);
        end
    end

    assign exp_per = exp_period(type_q);
    assign gate    = init_i | abort_i;

    // Next-state logic: reset beats abort, abort beats normal sequencing.
    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        type_d     = type_q;
        count_d    = count_q;
        begin_d    = begin_q;
        lcnt_d     = lcnt_q;
        gen_init_d = gen_init_q;
        busy_d     = busy_q;
        rtype_d    = rtype_q;
        rpass_d    = rpass_q;
        rperiod_d  = rperiod_q;
        pmask_d    = pmask_q;
        if (init_i) begin
            state_d    = S_IDLE;
            mask_d     = '0;
            type_d     = '0;
            count_d    = '0;
            begin_d    = '0;
            lcnt_d     = '0;
            gen_init_d = 1'b1;
            busy_d     = 1'b0;
            rtype_d    = '0;
            rpass_d    = 1'b0;
            rperiod_d  = '0;
            pmask_d    = '0;
        end else if (abort_i && state_q != S_IDLE) begin
            state_d    = S_IDLE;
            gen_init_d = 1'b1;
            busy_d     = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        mask_d  = type_mask_i;
                        pmask_d = '0;
                        busy_d  = 1'b1;
                        state_d = S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (|mask_q) begin
                        type_d  = sel_k;
                        mask_d  = mask_q & ~(9'd1 << sel_k);
                        lcnt_d  = '0;
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_FINISH;
                    end
                end
                S_LOAD: begin
                    if (lcnt_q == LOAD_LAST) begin
                        begin_d    = gen_out_i;
                        count_d    = '0;
                        gen_init_d = 1'b0;
                        state_d    = S_RUN;
                    end else begin
                        lcnt_d = lcnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    count_d = count_q + 32'd1;
                    if (gen_out_i == begin_q && count_q != '0) begin
                        rperiod_d = count_q;
                        rpass_d   = (count_q == exp_per);
                        rtype_d   = type_q;
                        state_d   = S_REPORT;
                    end else if (count_q == exp_per + 32'd1) begin
                        rperiod_d = count_q;
                        rpass_d   = 1'b0;
                        rtype_d   = type_q;
                        state_d   = S_REPORT;
                    end
                end
                S_REPORT: begin
                    pmask_d[type_q] = rpass_q;
                    gen_init_d      = 1'b1;
                    state_d         = S_SELECT;
                end
                S_FINISH: begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock_i) begin
        state_q    <= state_d;
        mask_q     <= mask_d;
        type_q     <= type_d;
        count_q    <= count_d;
        begin_q    <= begin_d;
        lcnt_q     <= lcnt_d;
        gen_init_q <= gen_init_d;
        busy_q     <= busy_d;
        rtype_q    <= rtype_d;
        rpass_q    <= rpass_d;
        rperiod_q  <= rperiod_d;
        pmask_q    <= pmask_d;
    end

    assign gen_init_o      = gen_init_q;
    assign gen_type_o      = type_q;
    assign busy_o          = busy_q;
    assign result_valid_o  = (state_q == S_REPORT) & ~gate;
    assign result_type_o   = rtype_q;
    assign result_pass_o   = rpass_q;
    assign result_period_o = rperiod_q;
    assign pass_mask_o     = pmask_q;
    assign done_o          = (state_q == S_FINISH) & ~gate;

endmodule

// File: tb/tb_prbs_sweep_ctrl.sv
// Bench for prbs_sweep_ctrl: per-cycle trace model of each sweep plus
// directed literal checks and randomized sweeps with aborts and resets.
module tb_prbs_sweep_ctrl;

    localparam int INIT = 5;
    localparam int LIMIT = 20000;
    localparam longint unsigned EXPP [9] = '{127, 511, 1023, 2047, 32767,
        1048575, 8388607, 536870911, 2147483647};

    logic        clk = 1'b0;
    logic        init, start, abort;
    logic [8:0]  type_mask;
    logic [31:0] gen_out;
    logic        gen_init, busy, result_valid, result_pass, done;
    logic [3:0]  gen_type, result_type;
    logic [31:0] result_period;
    logic [8:0]  pass_mask;

    prbs_sweep_ctrl #(.INIT_CYCLES(INIT)) dut (
        .clock_i(clk), .init_i(init), .start_i(start), .abort_i(abort),
        .type_mask_i(type_mask), .gen_out_i(gen_out),
        .gen_init_o(gen_init), .gen_type_o(gen_type), .busy_o(busy),
        .result_valid_o(result_valid), .result_type_o(result_type),
        .result_pass_o(result_pass), .result_period_o(result_period),
        .pass_mask_o(pass_mask), .done_o(done)
    );

    always #5 clk = ~clk;

    // Generator: 0 correct, 1 stuck, 2 never repeats, 3 fixed period gq.
    int              gmode = 0;
    longint unsigned gq = 1;
    longint unsigned pos = 0;

    always @(posedge clk) begin
        longint unsigned per;
        per = 0;
        if (gmode == 0 && gen_type < 9) per = EXPP[gen_type];
        if (gmode == 3) per = gq;
        if (gen_init) pos <= 0;
        else if (per != 0 && pos + 1 == per) pos <= 0;
        else pos <= pos + 1;
    end

    assign gen_out = (gmode == 1) ? 32'h5A5A5A5A : (pos[31:0] ^ 32'hC3A50F96);

    typedef struct {
        bit busy, gi, rv, done, gtv, rpass;
        int unsigned gtype, rtype;
        longint unsigned rperiod;
        bit [8:0] pm;
    } rec_t;

    rec_t     exp_q[$];
    bit       sweeping = 0;
    bit       armed = 0;
    bit [8:0] idle_pm = '0;
    int       checks = 0, failures = 0;
    int       cyc = 0, rv_cnt = 0, done_cnt = 0, done_cyc = 0;
    int       log_t[$];
    longint unsigned log_p[$];
    bit       log_ok[$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic rec_t mk(bit b, bit g, bit v, bit d, bit t,
                                int unsigned ty, bit [8:0] p);
        rec_t r;
        r.busy = b; r.gi = g; r.rv = v; r.done = d; r.gtv = t;
        r.gtype = ty; r.pm = p;
        r.rtype = 0; r.rpass = 0; r.rperiod = 0;
        return r;
    endfunction

    // Period the controller must report for type k under the current generator.
    function automatic void meas(input int k, output longint unsigned p,
                                 output bit ok);
        longint unsigned q;
        q = 0;
        if (gmode == 0) q = EXPP[k];
        if (gmode == 1) q = 1;
        if (gmode == 3) q = gq;
        if (q != 0 && q <= EXPP[k] + 1) p = q;
        else p = EXPP[k] + 1;
        ok = (q == EXPP[k]);
    endfunction

    // Expected trace from the cycle after start through the done cycle.
    function automatic void build(input bit [8:0] m);
        bit [8:0] pm;
        rec_t r;
        longint unsigned p;
        bit ok;
        pm = '0;
        exp_q.delete();
        for (int k = 0; k < 9; k++) begin
            if (m[k]) begin
                exp_q.push_back(mk(1, 1, 0, 0, 0, 0, pm));
                for (int i = 0; i < INIT; i++)
                    exp_q.push_back(mk(1, 1, 0, 0, 1, k, pm));
                meas(k, p, ok);
                for (longint unsigned i = 0; i <= p; i++)
                    exp_q.push_back(mk(1, 0, 0, 0, 1, k, pm));
                r = mk(1, 0, 1, 0, 1, k, pm);
                r.rtype = k; r.rpass = ok; r.rperiod = p;
                exp_q.push_back(r);
                pm[k] = ok;
            end
        end
        exp_q.push_back(mk(1, 1, 0, 0, 0, 0, pm));
        exp_q.push_back(mk(1, 1, 0, 1, 0, 0, pm));
    endfunction

    task automatic compare();
        rec_t r;
        bit g;
        g = init | abort;
        r = sweeping ? exp_q[0] : mk(0, 1, 0, 0, 0, 0, idle_pm);
        chk("busy", busy, r.busy);
        chk("gen_init", gen_init, r.gi);
        chk("result_valid", result_valid, r.rv & ~g);
        chk("done", done, r.done & ~g);
        chk("pass_mask", pass_mask, r.pm);
        if (r.gtv) chk("gen_type", gen_type, r.gtype);
        if (r.rv && !g) begin
            chk("result_type", result_type, r.rtype);
            chk("result_pass", result_pass, r.rpass);
            chk("result_period", result_period, r.rperiod);
        end
        if (result_valid === 1'b1) begin
            rv_cnt++;
            log_t.push_back(result_type);
            log_p.push_back(result_period);
            log_ok.push_back(result_pass);
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    task automatic advance();
        if (init) begin
            sweeping = 0; exp_q.delete(); idle_pm = '0; armed = 1;
        end else if (sweeping && abort) begin
            idle_pm = exp_q[0].pm; sweeping = 0; exp_q.delete();
        end else if (sweeping) begin
            idle_pm = exp_q[0].pm;
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) sweeping = 0;
        end else if (start) begin
            build(type_mask); sweeping = 1;
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (armed) compare();
        advance();
        @(posedge clk);
        #1;
    endtask

    int start_cyc;

    task automatic run_sweep(input bit [8:0] m, input int mode,
                             input longint unsigned q, input int ab_off,
                             input int in_off, input int bs_off);
        int n;
        gmode = mode; gq = q;
        rv_cnt = 0; done_cnt = 0; done_cyc = 0;
        log_t.delete(); log_p.delete(); log_ok.delete();
        start = 1; type_mask = m;
        start_cyc = cyc + 1;
        step();
        start = 0; type_mask = 9'($urandom);
        n = 0;
        while (sweeping && n < LIMIT) begin
            n++;
            abort = (n == ab_off);
            init  = (n == in_off);
            start = (n == bs_off);
            if (start) type_mask = 9'($urandom);
            step();
            abort = 0; init = 0; start = 0;
        end
        if (sweeping) begin
            checks++; failures++;
            $display("FAIL sweep_timeout cyc=%0d actual=busy expected=done", cyc);
            init = 1; step(); init = 0;
        end
    endtask

    initial begin
        init = 1; start = 0; abort = 0; type_mask = '0;
        @(posedge clk); #1;
        step(); step();
        init = 0;
        chk("rst_gen_init", gen_init, 1);
        chk("rst_gen_type", gen_type, 0);
        chk("rst_busy", busy, 0);
        chk("rst_period", result_period, 0);
        chk("rst_type", result_type, 0);
        chk("rst_pass", result_pass, 0);
        chk("rst_pmask", pass_mask, 0);
        step();

        run_sweep(9'h001, 0, 1, 0, 0, 0);
        chk("one_rv", rv_cnt, 1);
        chk("one_period", log_p.size() > 0 ? log_p[0] : 0, 127);
        chk("one_pass", log_ok.size() > 0 ? log_ok[0] : 0, 1);
        chk("one_pmask", pass_mask, 9'h001);
        chk("one_done", done_cnt, 1);
        step();

        run_sweep(9'h00F, 0, 1, 0, 0, 40);
        chk("four_rv", rv_cnt, 4);
        for (int i = 0; i < 4 && i < log_p.size(); i++) begin
            chk("four_type", log_t[i], i);
            chk("four_period", log_p[i], EXPP[i]);
        end
        chk("four_pmask", pass_mask, 9'h00F);
        step();

        run_sweep(9'h002, 1, 1, 0, 0, 0);
        chk("stuck_period", result_period, 1);
        chk("stuck_pass", result_pass, 0);
        step();

        run_sweep(9'h001, 2, 1, 0, 0, 0);
        chk("never_period", result_period, 128);
        chk("never_pass", result_pass, 0);
        step();

        run_sweep(9'h000, 0, 1, 0, 0, 0);
        chk("empty_latency", done_cyc - start_cyc, 2);
        chk("empty_rv", rv_cnt, 0);
        chk("empty_pmask", pass_mask, 0);
        step();

        run_sweep(9'h003, 0, 1, 20, 0, 0);
        chk("abort_busy", busy, 0);
        chk("abort_gen_init", gen_init, 1);
        chk("abort_done", done_cnt, 0);
        step();

        run_sweep(9'h003, 3, 50, 0, 30, 0);
        chk("init_busy", busy, 0);
        chk("init_gen_init", gen_init, 1);
        chk("init_done", done_cnt, 0);
        chk("init_pmask", pass_mask, 0);
        step();

        for (int t = 0; t < 12; t++) begin
            int mode, ab, in, bs;
            bit [8:0] m;
            longint unsigned q;
            mode = $urandom_range(0, 3);
            q = $urandom_range(1, 300);
            m = (mode == 0 || mode == 2) ? 9'($urandom_range(0, 7)) : 9'($urandom);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 400) : 0;
            in = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 400) : 0;
            bs = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 50) : 0;
            run_sweep(m, mode, q, ab, in, bs);
            repeat ($urandom_range(1, 3)) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
